uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter (UART_TOP) between N requesters using round-robin arbitration.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_if.sv | 41 ++++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM type, width defaults and parity constants for the UART TX arbiter slice.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ISSUE      = 2'd1,
      ST_WAIT_START = 2'd2,
      ST_WAIT_DONE  = 2'd3
   } arb_state_t;

   localparam int DATA_W_DEF = 8;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and UART-TX-side signals of the shared transmitter arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = uart_pkg::DATA_W_DEF
);
   localparam int IDX_W = uart_pkg::idx_width(NUM_REQ);

   // requester side
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        ack;
   logic                      cfg_parity_en;
   logic                      cfg_parity_type;

   // UART TX side
   logic                      tx_data_valid;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_parity_en;
   logic                      tx_parity_type;
   logic                      tx_busy;

   // status
   logic [IDX_W-1:0]          owner;
   logic                      arb_busy;
   logic                      err_tmo;

   // the arbiter itself
   modport slave (
      input  req, req_data, cfg_parity_en, cfg_parity_type, tx_busy,
      output ack, tx_data_valid, tx_data, tx_parity_en, tx_parity_type,
             owner, arb_busy, err_tmo
   );

   // whatever surrounds the arbiter (producers plus the transmitter)
   modport master (
      output req, req_data, cfg_parity_en, cfg_parity_type, tx_busy,
      input  ack, tx_data_valid, tx_data, tx_parity_en, tx_parity_type,
             owner, arb_busy, err_tmo
   );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; first set request at or above ptr, wrapping around.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   logic [IDX_W-1:0]   cand_idx [NUM_REQ];
   logic [NUM_REQ-1:0] cand_hit;

   // Candidate gi is the requester gi positions after ptr, folded back into 0..NUM_REQ-1.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                         : sum[IDX_W-1:0];
      assign cand_hit[gi] = req[cand_idx[gi]];
   end

   // Lowest rotation offset with a live request wins (scan high to low so it lands last).
   always_comb begin
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand_hit[k]) begin
            grant_idx   = cand_idx[k];
            grant_valid = 1'b1;
         end
      end
   end

   // One-hot form of the winning index.
   always_comb begin
      grant = '0;
      if (grant_valid) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between NUM_REQ byte producers.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int BUSY_TMO = 4
) (
   input  logic             CLK,
   input  logic             RST,
   uart_tx_arbiter_if.slave bus
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int CNT_W = $clog2(BUSY_TMO + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   // Counter value during the last WAIT_START cycle before giving up.
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TMO - 1);

   arb_state_t         state_reg, state_next;
   logic [IDX_W-1:0]   rr_ptr_reg;
   logic [IDX_W-1:0]   owner_reg;
   logic [NUM_REQ-1:0] ack_hot_reg;
   logic [DATA_W-1:0]  data_reg;
   logic               par_en_reg;
   logic               par_type_reg;
   logic               err_tmo_reg;
   logic [CNT_W-1:0]   cnt_reg;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_valid;
   logic               grant_fire;
   logic               tmo_hit;
   logic               frame_done;

   logic               tx_data_valid_o;
   logic [NUM_REQ-1:0] ack_o;
   logic               arb_busy_o;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req         (bus.req),
      .ptr         (rr_ptr_reg),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // A foreign frame on the line (busy while idle) blocks any grant.
   assign grant_fire = (state_reg == ST_IDLE) && grant_valid && !bus.tx_busy;
   assign tmo_hit    = (state_reg == ST_WAIT_START) && !bus.tx_busy && (cnt_reg == TMO_LAST);
   assign frame_done = (state_reg == ST_WAIT_DONE) && !bus.tx_busy;

   // State register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_reg <= ST_IDLE;
      else      state_reg <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:       if (grant_fire) state_next = ST_ISSUE;
         ST_ISSUE:      state_next = ST_WAIT_START;
         ST_WAIT_START: if (bus.tx_busy) state_next = ST_WAIT_DONE;
                        else if (tmo_hit) state_next = ST_IDLE;
         ST_WAIT_DONE:  if (!bus.tx_busy) state_next = ST_IDLE;
         default:       state_next = ST_IDLE;
      endcase
   end

   // Outputs decoded from the state; reset forces IDLE so pulses drop at once.
   always_comb begin
      tx_data_valid_o = (state_reg == ST_ISSUE);
      ack_o           = (state_reg == ST_ISSUE) ? ack_hot_reg : '0;
      arb_busy_o      = (state_reg != ST_IDLE);
   end

   // Capture winner, byte and parity config at the grant edge; held until the next grant.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         owner_reg    <= '0;
         ack_hot_reg  <= '0;
         data_reg     <= '0;
         par_en_reg   <= 1'b0;
         par_type_reg <= PARITY_EVEN;
      end else if (grant_fire) begin
         owner_reg    <= grant_idx;
         ack_hot_reg  <= grant;
         data_reg     <= bus.req_data[grant_idx*DATA_W +: DATA_W];
         par_en_reg   <= bus.cfg_parity_en;
         par_type_reg <= bus.cfg_parity_type;
      end
   end

   // Pointer moves past the owner only once its frame has fully completed.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)            rr_ptr_reg <= '0;
      else if (frame_done) rr_ptr_reg <= (owner_reg == LAST_IDX) ? '0 : owner_reg + IDX_W'(1);
   end

   // Cycles spent waiting for the transmitter to report busy.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                             cnt_reg <= '0;
      else if (state_reg == ST_WAIT_START)  cnt_reg <= cnt_reg + CNT_W'(1);
      else                                  cnt_reg <= '0;
   end

   // Sticky timeout flag.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)         err_tmo_reg <= 1'b0;
      else if (tmo_hit) err_tmo_reg <= 1'b1;
   end

   assign bus.ack            = ack_o;
   assign bus.tx_data_valid  = tx_data_valid_o;
   assign bus.tx_data        = data_reg;
   assign bus.tx_parity_en   = par_en_reg;
   assign bus.tx_parity_type = par_type_reg;
   assign bus.owner          = owner_reg;
   assign bus.arb_busy       = arb_busy_o;
   assign bus.err_tmo        = err_tmo_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed + randomized checks of the arbiter against a simple UART TX model.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   logic CLK = 1'b0;
   logic RST;

   uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .BUSY_TMO(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // 104 us bit period at 1 time unit = 1 us.
   always #52 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   int txn   = 0;

   // Behavioural UART transmitter: busy for one whole frame after a data_valid pulse.
   logic m_en;
   logic m_force;
   logic m_busy;
   int   m_idx;
   int   m_len;
   logic line;

   assign m_len       = bus.tx_parity_en ? 11 : 10;
   assign bus.tx_busy = m_busy | m_force;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         m_busy <= 1'b0;
         m_idx  <= 0;
      end else if (!m_busy) begin
         if (bus.tx_data_valid && m_en) begin
            m_busy <= 1'b1;
            m_idx  <= 0;
         end
      end else if (m_idx == m_len - 1) begin
         m_busy <= 1'b0;
         m_idx  <= 0;
      end else begin
         m_idx <= m_idx + 1;
      end
   end

   // Line bit built from the arbiter's live outputs, so any mid-frame change shows up.
   always_comb begin
      line = 1'b1;
      if (m_busy) begin
         if (m_idx == 0)                             line = 1'b0;
         else if (m_idx <= 8)                        line = bus.tx_data[m_idx-1];
         else if (m_idx == 9 && bus.tx_parity_en)    line = (^bus.tx_data) ^ bus.tx_parity_type;
         else                                        line = 1'b1;
      end
   end

   // Reference state.
   logic [7:0] data_m [4];
   int         ptr_m;
   logic       err_exp;
   logic       cfg_en;
   logic       cfg_type;

   function automatic int rr_pick(input logic [3:0] m, input int p);
      for (int k = 0; k < 4; k++)
         if (m[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input logic en, input logic ty);
      cfg_en = en;
      cfg_type = ty;
      bus.cfg_parity_en = en;
      bus.cfg_parity_type = ty;
   endtask

   task automatic set_data(input int i, input logic [7:0] d);
      data_m[i] = d;
      bus.req_data[i*8 +: 8] = d;
   endtask

   // Wait for the ISSUE cycle and check everything presented with it.
   task automatic serve(input int win);
      int n;
      bit got;
      logic [3:0] hot;
      n = 0;
      got = 0;
      while (!got && n < 300) begin
         @(negedge CLK);
         n++;
         if (bus.ack !== 4'b0) got = 1;
      end
      check("ack_seen", 32'(got), 32'd1);
      hot = 4'b0001 << win;
      check("ack_onehot", 32'(bus.ack), 32'(hot));
      check("data_valid", 32'(bus.tx_data_valid), 32'd1);
      check("tx_data", 32'(bus.tx_data), 32'(data_m[win]));
      check("owner", 32'(bus.owner), 32'(win));
      check("parity_en", 32'(bus.tx_parity_en), 32'(cfg_en));
      check("parity_type", 32'(bus.tx_parity_type), 32'(cfg_type));
      check("grant_latency", 32'(n), 32'd1);
      txn++;
      $display("txn %0d: winner=%0d data=%02h parity_en=%0b parity_type=%0b wait=%0d",
               txn, win, data_m[win], cfg_en, cfg_type, n);
   endtask

   // Follow the frame to the end, collect the line and check the release timing.
   task automatic finish_frame(input logic [7:0] d, input logic en, input logic ty,
                               input int win, input bit toggle, input int pulse);
      logic q[$];
      logic [15:0] obs_bits, exp_bits;
      int exp_len, fall_at, arb_at, spur;
      bit seen_busy, done;
      fall_at = -1; arb_at = -1; spur = 0; seen_busy = 0; done = 0;
      for (int n = 1; n <= 400 && !done; n++) begin
         @(negedge CLK);
         if (n == 1) check("dv_single_cycle", 32'(bus.tx_data_valid), 32'd0);
         if (bus.ack !== 4'b0) spur++;
         if (toggle && n == 3) set_cfg(~cfg_en, ~cfg_type);
         if (pulse >= 0 && n == 2) bus.req[pulse] = 1'b1;
         if (pulse >= 0 && n == 4) bus.req[pulse] = 1'b0;
         if (bus.tx_busy) begin
            q.push_back(line);
            seen_busy = 1;
         end else if (seen_busy && fall_at < 0) begin
            fall_at = n;
         end
         if (!bus.arb_busy) begin
            done = 1;
            arb_at = n;
         end
      end
      check("frame_end_seen", 32'(done), 32'd1);
      check("no_ack_in_frame", 32'(spur), 32'd0);
      check("arb_busy_release", 32'(arb_at - fall_at), 32'd1);
      exp_bits = '1;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits[1+i] = d[i];
      if (en) exp_bits[9] = (^d) ^ ty;
      exp_len = en ? 11 : 10;
      obs_bits = '1;
      for (int i = 0; i < q.size() && i < 16; i++) obs_bits[i] = q[i];
      check("frame_len", 32'(q.size()), 32'(exp_len));
      check("line_bits", 32'(obs_bits), 32'(exp_bits));
      check("err_tmo", 32'(bus.err_tmo), 32'(err_exp));
      ptr_m = (win + 1) % 4;
   endtask

   task automatic one_frame(input int win, input bit toggle, input int pulse, input bit drop);
      logic [7:0] d;
      logic en, ty;
      serve(win);
      d = data_m[win];
      en = cfg_en;
      ty = cfg_type;
      if (drop) bus.req[win] = 1'b0;
      finish_frame(d, en, ty, win, toggle, pulse);
   endtask

   initial begin
      #(104 * 20000);
      $display("FAIL watchdog: simulation did not finish within the cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] pending, newbits;
      int seen, win;

      // ---- reset state
      RST = 1'b0;
      bus.req = '0;
      bus.req_data = '0;
      set_cfg(1'b0, PARITY_EVEN);
      m_en = 1'b1;
      m_force = 1'b0;
      ptr_m = 0;
      err_exp = 1'b0;
      for (int i = 0; i < 4; i++) set_data(i, 8'h00);
      repeat (3) @(negedge CLK);
      check("rst_ack", 32'(bus.ack), 32'd0);
      check("rst_dv", 32'(bus.tx_data_valid), 32'd0);
      RST = 1'b1;
      @(negedge CLK);
      check("rst_owner", 32'(bus.owner), 32'd0);
      check("rst_arb_busy", 32'(bus.arb_busy), 32'd0);
      check("rst_err", 32'(bus.err_tmo), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'd0);

      // ---- all requesting: order 0,1,2,3,0 with requests held
      for (int i = 0; i < 4; i++) set_data(i, 8'(8'h11 * (i + 1)));
      bus.req = 4'b1111;
      for (int f = 0; f < 5; f++) one_frame(rr_pick(4'b1111, ptr_m), 1'b0, -1, 1'b0);
      bus.req = 4'b0000;
      @(negedge CLK);

      // ---- single request, parity off
      set_data(1, 8'hAA);
      set_cfg(1'b0, PARITY_EVEN);
      bus.req = 4'b0010;
      one_frame(rr_pick(4'b0010, ptr_m), 1'b0, -1, 1'b1);

      // ---- parity latched at grant, cfg toggled mid-frame
      set_data(0, 8'hE4);
      set_cfg(1'b1, PARITY_ODD);
      bus.req = 4'b0001;
      one_frame(rr_pick(4'b0001, ptr_m), 1'b1, -1, 1'b1);
      set_cfg(1'b0, PARITY_EVEN);

      // ---- withdrawn request during a frame, later request served next
      set_data(0, 8'h5C);
      set_data(2, 8'h77);
      set_data(3, 8'h3D);
      bus.req = 4'b0001;
      one_frame(rr_pick(4'b0001, ptr_m), 1'b0, 2, 1'b1);
      bus.req = 4'b1000;
      one_frame(rr_pick(4'b1000, ptr_m), 1'b0, -1, 1'b1);

      // ---- foreign busy while idle: nothing granted until the line frees
      m_force = 1'b1;
      set_data(1, 8'h96);
      bus.req = 4'b0010;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         if (bus.ack !== 4'b0 || bus.arb_busy !== 1'b0) seen++;
      end
      check("foreign_busy_hold", 32'(seen), 32'd0);
      m_force = 1'b0;
      one_frame(rr_pick(4'b0010, ptr_m), 1'b0, -1, 1'b1);

      // ---- busy timeout: 4 WAIT_START cycles, then err_tmo and a retry to the same owner
      m_en = 1'b0;
      set_data(2, 8'hC3);
      bus.req = 4'b0100;
      serve(rr_pick(4'b0100, ptr_m));
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         check("tmo_waiting", 32'(bus.arb_busy), 32'd1);
         check("tmo_err_early", 32'(bus.err_tmo), 32'd0);
      end
      @(negedge CLK);
      check("tmo_err_set", 32'(bus.err_tmo), 32'd1);
      check("tmo_back_idle", 32'(bus.arb_busy), 32'd0);
      err_exp = 1'b1;
      m_en = 1'b1;
      one_frame(rr_pick(4'b0100, ptr_m), 1'b0, -1, 1'b1);

      // ---- randomized traffic against the reference model
      pending = 4'b0000;
      for (int it = 0; it < 16; it++) begin
         newbits = 4'($urandom_range(0, 15));
         if ((pending | newbits) == 4'b0000) newbits = 4'b0001 << $urandom_range(0, 3);
         for (int i = 0; i < 4; i++)
            if (newbits[i] && !pending[i]) set_data(i, 8'($urandom));
         pending = pending | newbits;
         bus.req = pending;
         set_cfg(1'($urandom), 1'($urandom));
         win = rr_pick(pending, ptr_m);
         pending[win] = 1'b0;
         one_frame(win, 1'($urandom_range(0, 1)), -1, 1'b1);
      end
      bus.req = 4'b0000;
      @(negedge CLK);

      // ---- reset in the middle of ISSUE
      set_data(2, 8'h81);
      bus.req = 4'b0100;
      @(negedge CLK);
      check("pre_rst_ack", 32'(bus.ack), 32'h4);
      RST = 1'b0;
      #1;
      check("rst_mid_ack", 32'(bus.ack), 32'd0);
      check("rst_mid_dv", 32'(bus.tx_data_valid), 32'd0);
      check("rst_mid_arb", 32'(bus.arb_busy), 32'd0);
      bus.req = 4'b0000;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check("post_rst_owner", 32'(bus.owner), 32'd0);
      check("post_rst_arb", 32'(bus.arb_busy), 32'd0);
      check("post_rst_err", 32'(bus.err_tmo), 32'd0);
      ptr_m = 0;
      err_exp = 1'b0;
      set_data(1, 8'h2B);
      set_data(3, 8'hD0);
      bus.req = 4'b1010;
      one_frame(rr_pick(4'b1010, ptr_m), 1'b0, -1, 1'b1);
      bus.req = 4'b0000;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
